axi_burst_master: RTL
=====================

Name: axi_burst_master

Overview:
- AXI4 master engine that replaces the tied-off master channels of the CPU core with a working burst read/write path.
- Accepts one command at a time (address, beat count, direction) from the CPU side.
- Runs a single INCR burst on M_AXI, streaming write data in and read data out.
- Reports per-command completion and error status.

Parameters:
C_M_AXI_ADDR_WIDTH, 32, AXI address width
C_M_AXI_DATA_WIDTH, 32, AXI data width (32 or 64)
C_M_AXI_ID_WIDTH, 1, AWID/ARID width, driven 0
C_MAX_BURST_LEN, 16, max beats per command (1..256)

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
CMD_VALID  in  1  command valid
CMD_READY  out  1  engine idle, command accepted when VALID&READY
CMD_WRITE  in  1  1=write, 0=read
CMD_ADDR  in  C_M_AXI_ADDR_WIDTH  start byte address, beat-aligned
CMD_LEN  in  8  beats minus 1
WD_VALID / WD_READY / WD_DATA  in/out/in  1/1/DATA_WIDTH  write-data stream
RD_VALID / RD_READY / RD_DATA / RD_LAST  out/in/out/out  1/1/DATA_WIDTH/1  read-data stream
DONE  out  1  one-cycle pulse at command completion
ERR  out  1  error status of last completed command
M_AXI_AW{ID,ADDR,LEN,VALID} out, M_AXI_AWREADY in  AXI4 write address
M_AXI_W{DATA,STRB,LAST,VALID} out, M_AXI_WREADY in  AXI4 write data
M_AXI_B{ID,RESP,VALID} in, M_AXI_BREADY out  AXI4 write response
M_AXI_AR{ID,ADDR,LEN,VALID} out, M_AXI_ARREADY in  AXI4 read address
M_AXI_R{ID,DATA,RESP,LAST,VALID} in, M_AXI_RREADY out  AXI4 read data
M_AXI_{AW,AR}{SIZE,BURST,LOCK,CACHE,PROT,QOS,USER}, M_AXI_WUSER  out  std  constant attributes

Behaviour:
- Constant attributes:
  - SIZE = log2(DATA_WIDTH/8); BURST = 01 (INCR); LOCK = 0; CACHE = 0011; PROT = 0; QOS = 0; USER = 0.
  - WSTRB all ones; IDs 0.
- Reset (ARESETN low, asynchronous):
  - State IDLE.
  - All *VALID, BREADY, RREADY, DONE, ERR = 0; CMD_READY = 0 while reset is asserted.
  - Address/len registers cleared.
- FSM states: IDLE, CHECK, AW, W, B, AR, R, FIN.
- IDLE:
  - CMD_READY = 1; the command is registered on handshake; next state CHECK.
- CHECK (1 cycle):
  - If CMD_LEN+1 > C_MAX_BURST_LEN, or the burst crosses a 4 KB boundary ((addr & 0xFFF) + (len+1)*bytes > 4096): set err_r, go to FIN. No bus activity.
  - Else go to AW (write) or AR (read).
- AW / AR:
  - VALID held high, with ADDR/LEN stable, until READY is sampled.
  - Then go to W / R. VALID must not drop before the handshake.
- W:
  - M_AXI_WVALID = WD_VALID; WD_READY = M_AXI_WREADY; WDATA = WD_DATA (combinational pass-through, zero latency).
  - Beat counter increments on each WVALID&WREADY.
  - WLAST = (count == len).
  - On the last-beat handshake go to B.
- B:
  - BREADY = 1.
  - On BVALID, err_r |= (BRESP != 00); go to FIN.
- R:
  - RREADY = RD_READY; RD_VALID = M_AXI_RVALID; RD_DATA = RDATA; RD_LAST = RLAST.
  - Count beats on RVALID&RREADY; err_r |= (RRESP != 00) on any beat.
  - RLAST early (count < len) or missing on the final beat: err_r = 1.
  - Leave R on the handshake where RLAST=1 or count==len, whichever comes first.
- FIN (1 cycle):
  - DONE = 1; ERR <= err_r; err_r cleared; go to IDLE.
  - Latency: the next command can be accepted the cycle after FIN.
- ERR holds its value until the next FIN updates it.
- Only one outstanding transaction; AW before W, no write-data interleave.
- Simultaneous CMD_VALID during any non-IDLE state: ignored (CMD_READY = 0).
- Reset mid-burst: the FSM aborts immediately to IDLE. The interconnect/slave must share ARESETN; no protocol recovery is attempted.

Test Plan:
- Write, addr 0x1000_0000, CMD_LEN=0, data 0xDEADBEEF, AWREADY delayed 3 cycles → AWLEN=0, one W beat with WLAST=1, BRESP=00 → DONE pulse, ERR=0.
- Read, addr 0x2000, CMD_LEN=3, slave returns 0x11,0x22,0x33,0x44; RD_READY toggles every other cycle → RD_DATA order preserved, RD_LAST on 0x44, no beat lost/duplicated, DONE, ERR=0.
- Write, CMD_LEN=3, WREADY/WD_VALID randomly stalled → exactly 4 beats, WLAST only on the 4th, BRESP=10 → ERR=1 after DONE; the next clean command clears ERR to 0.
- CMD_LEN=16 with C_MAX_BURST_LEN=16, and separately addr 0x0FF8 with CMD_LEN=3 (32-bit) → no AWVALID/ARVALID ever asserted, DONE after 2 cycles, ERR=1.
- Read CMD_LEN=3 with slave asserting RLAST on beat 2 → engine exits R after beat 2, ERR=1, CMD_READY back high.
- ARESETN pulsed low mid write burst (beat 2 of 4) → all VALID/READY outputs 0 asynchronously; after release CMD_READY=1 and a new read completes normally.

Source files
------------

// File: rtl/axi_burst_master.sv
// rtl/axi_burst_master.sv - single-command AXI4 INCR burst master with streamed write/read data
// One command in flight: CHECK screens length and 4 KB crossing before any bus traffic.
module axi_burst_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_MAX_BURST_LEN    = 16
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            CMD_VALID,
  output logic                            CMD_READY,
  input  logic                            CMD_WRITE,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   CMD_ADDR,
  input  logic [7:0]                      CMD_LEN,
  input  logic                            WD_VALID,
  output logic                            WD_READY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   WD_DATA,
  output logic                            RD_VALID,
  input  logic                            RD_READY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   RD_DATA,
  output logic                            RD_LAST,
  output logic                            DONE,
  output logic                            ERR,
  output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_AWID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]                      M_AXI_AWLEN,
  output logic [2:0]                      M_AXI_AWSIZE,
  output logic [1:0]                      M_AXI_AWBURST,
  output logic                            M_AXI_AWLOCK,
  output logic [3:0]                      M_AXI_AWCACHE,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic [3:0]                      M_AXI_AWQOS,
  output logic                            M_AXI_AWUSER,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WLAST,
  output logic                            M_AXI_WUSER,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_BID,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]                      M_AXI_ARLEN,
  output logic [2:0]                      M_AXI_ARSIZE,
  output logic [1:0]                      M_AXI_ARBURST,
  output logic                            M_AXI_ARLOCK,
  output logic [3:0]                      M_AXI_ARCACHE,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic [3:0]                      M_AXI_ARQOS,
  output logic                            M_AXI_ARUSER,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RLAST,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int         SIZE_I    = $clog2(C_M_AXI_DATA_WIDTH / 8);
  localparam logic [2:0] AXSIZE    = 3'(SIZE_I);
  localparam logic [8:0] MAX_BEATS = 9'(C_MAX_BURST_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_AW, S_W, S_B, S_AR, S_R, S_FIN
  } state_t;

  state_t                          state_q, state_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]                      len_q, len_d;
  logic [7:0]                      cnt_q, cnt_d;
  logic                            write_q, write_d;
  logic                            err_q, err_d;
  logic                            err_out_q, err_out_d;

  logic [8:0]  beats;
  logic [13:0] burst_bytes;
  logic [13:0] end_offset;
  logic        cmd_bad;
  logic        w_hs;
  logic        w_last;
  logic        r_hs;
  logic        r_final;
  logic        unused_ok;

  // End offset within the 4 KB page; landing exactly on 4096 is still legal.
  assign beats       = {1'b0, len_q} + 9'd1;
  assign burst_bytes = 14'(beats) << SIZE_I;
  assign end_offset  = {2'b00, addr_q[11:0]} + burst_bytes;
  assign cmd_bad     = (beats > MAX_BEATS) || (end_offset > 14'd4096);

  assign w_last  = (cnt_q == len_q);
  assign w_hs    = (state_q == S_W) && WD_VALID && M_AXI_WREADY;
  assign r_final = (cnt_q == len_q);
  assign r_hs    = (state_q == S_R) && M_AXI_RVALID && RD_READY;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      err_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      write_q   <= write_d;
      err_q     <= err_d;
      err_out_q <= err_out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    err_d     = err_q;
    err_out_d = err_out_q;
    unique case (state_q)
      S_IDLE: begin
        if (CMD_VALID) begin
          addr_d  = CMD_ADDR;
          len_d   = CMD_LEN;
          write_d = CMD_WRITE;
          cnt_d   = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (cmd_bad) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          state_d = write_q ? S_AW : S_AR;
        end
      end
      S_AW: begin
        if (M_AXI_AWREADY) state_d = S_W;
      end
      S_W: begin
        if (w_hs) begin
          cnt_d = cnt_q + 8'd1;
          if (w_last) state_d = S_B;
        end
      end
      S_B: begin
        if (M_AXI_BVALID) begin
          err_d   = err_q | (M_AXI_BRESP != 2'b00);
          state_d = S_FIN;
        end
      end
      S_AR: begin
        if (M_AXI_ARREADY) state_d = S_R;
      end
      S_R: begin
        // RLAST must coincide with the final counted beat; either side early is an error.
        if (r_hs) begin
          cnt_d = cnt_q + 8'd1;
          if ((M_AXI_RRESP != 2'b00) || (M_AXI_RLAST != r_final)) err_d = 1'b1;
          if (M_AXI_RLAST || r_final) state_d = S_FIN;
        end
      end
      S_FIN: begin
        err_out_d = err_q;
        err_d     = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    CMD_READY     = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    WD_READY      = 1'b0;
    M_AXI_WLAST   = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    RD_VALID      = 1'b0;
    RD_LAST       = 1'b0;
    DONE          = 1'b0;
    unique case (state_q)
      S_IDLE: CMD_READY = ARESETN;
      S_AW:   M_AXI_AWVALID = 1'b1;
      S_W: begin
        M_AXI_WVALID = WD_VALID;
        WD_READY     = M_AXI_WREADY;
        M_AXI_WLAST  = w_last;
      end
      S_B:    M_AXI_BREADY = 1'b1;
      S_AR:   M_AXI_ARVALID = 1'b1;
      S_R: begin
        M_AXI_RREADY = RD_READY;
        RD_VALID     = M_AXI_RVALID;
        RD_LAST      = M_AXI_RLAST;
      end
      S_FIN:  DONE = 1'b1;
      default: ;
    endcase
  end

  assign ERR          = err_out_q;
  assign RD_DATA      = M_AXI_RDATA;
  assign M_AXI_WDATA  = WD_DATA;
  assign M_AXI_WSTRB  = '1;
  assign M_AXI_WUSER  = 1'b0;

  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWLEN   = len_q;
  assign M_AXI_AWSIZE  = AXSIZE;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = 4'b0011;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWQOS   = 4'b0000;
  assign M_AXI_AWUSER  = 1'b0;

  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARLEN   = len_q;
  assign M_AXI_ARSIZE  = AXSIZE;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = 4'b0011;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARQOS   = 4'b0000;
  assign M_AXI_ARUSER  = 1'b0;

  // Response IDs are irrelevant with a single outstanding transaction.
  assign unused_ok = &{1'b0, M_AXI_BID, M_AXI_RID};

endmodule
